// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus adapter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables, lane-replicated store data, load extraction
// with sign/zero extension, and legality of the width/offset combination.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0;
    rdata_ext  = 32'h0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = {24'h0, byte_sel};
        illegal    = we;
      end
      F3_H: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
        illegal    = off[0];
      end
      F3_HU: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, half_sel};
        illegal    = off[0] | we;
      end
      F3_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        rdata_ext  = bus_rdata;
        illegal    = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bridging the single-cycle core to a ready/valid data bus:
// one core access becomes one bus transaction, with the core stalled meanwhile.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        stall,
  output logic        err_access,
  output logic        err_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err_in
);

  lsu_state_t       state_q, state_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [TMO_W-1:0] cnt_q, cnt_nxt;
  logic             idle, resp, tmo;
  logic [2:0]       al_f3;
  logic [1:0]       al_off;
  logic             al_we;
  logic [3:0]       be;
  logic [31:0]      lane_wdata, rdata_ext;
  logic             illegal;

  // The aligner decodes live core inputs in IDLE and the latched access afterwards.
  assign idle    = (state_q == IDLE);
  assign al_f3   = idle ? core_funct3    : f3_q;
  assign al_off  = idle ? core_addr[1:0] : off_q;
  assign al_we   = idle ? core_we        : we_q;
  assign stall   = core_req & (state_q != DONE);
  assign cnt_nxt = cnt_q + 1'b1;

  lsu_align u_align (
    .funct3     (al_f3),
    .off        (al_off),
    .we         (al_we),
    .wdata      (core_wdata),
    .bus_rdata  (bus_rdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .rdata_ext  (rdata_ext),
    .illegal    (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A response beats the timeout in the same cycle; the timeout beats a bare grant.
  always_comb begin
    state_d = state_q;
    resp    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (core_req) state_d = illegal ? DONE : REQ;
      REQ: begin
        if (bus_gnt && bus_rvalid) begin
          resp    = 1'b1;
          state_d = DONE;
        end else if (cnt_nxt == TMO_W'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = DONE;
        end else if (bus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          resp    = 1'b1;
          state_d = DONE;
        end else if (cnt_nxt == TMO_W'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
      core_rdata <= 32'h0;
      err_access <= 1'b0;
      err_bus    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (core_req) begin
            if (illegal) begin
              err_access <= 1'b1;
            end else begin
              we_q      <= core_we;
              f3_q      <= core_funct3;
              off_q     <= core_addr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= core_we;
              bus_addr  <= {core_addr[31:2], 2'b00};
              bus_be    <= be;
              bus_wdata <= core_we ? lane_wdata : 32'h0;
            end
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_nxt;
          if (state_q == REQ && bus_gnt) bus_req <= 1'b0;
          if (resp) begin
            err_bus <= bus_err_in;
            if (bus_err_in)  core_rdata <= 32'h0;
            else if (!we_q)  core_rdata <= rdata_ext;
          end
          if (tmo) begin
            bus_req    <= 1'b0;
            err_bus    <= 1'b1;
            core_rdata <= 32'h0;
          end
        end
        DONE: begin
          err_access <= 1'b0;
          err_bus    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: stores, loads, illegal accesses, timeout, reset.
module tb_lsu_bus_adapter;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        stall, err_access, err_bus;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err_in;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_bus_adapter #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .stall       (stall),
    .err_access  (err_access),
    .err_bus     (err_bus),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err_in  (bus_err_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          stall_cyc, req_cyc;
  logic        saw_req;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] d_rdata;
  logic        d_eacc, d_ebus, d_breq, a_eacc, a_ebus;

  // gnt_wait: REQ cycles without grant (-1 = never). rsp_wait: WAIT cycles before
  // rvalid (-1 = rvalid together with gnt).
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_wait, input int rsp_wait,
                        input logic [31:0] rdata, input logic berr);
    int req_n, wait_n;
    bit granted, done;
    req_n = 0; wait_n = 0; granted = 0; done = 0;
    stall_cyc = 0; req_cyc = 0; saw_req = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0;
    core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    bus_rdata = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall) begin
        done    = 1;
        d_rdata = core_rdata;
        d_eacc  = err_access;
        d_ebus  = err_bus;
        d_breq  = bus_req;
      end else begin
        stall_cyc++;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (bus_req) begin
          req_cyc++;
          if (!saw_req) begin
            cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
          end
          saw_req = 1'b1;
        end
        if (!granted && bus_req) begin
          req_n++;
          if (gnt_wait >= 0 && req_n > gnt_wait) begin
            bus_gnt = 1'b1;
            granted = 1;
            if (rsp_wait < 0) bus_rvalid = 1'b1;
          end
        end else if (granted && rsp_wait >= 0) begin
          if (wait_n == rsp_wait) bus_rvalid = 1'b1;
          wait_n++;
        end
        bus_err_in = bus_rvalid & berr;
        tick();
      end
    end
    check("txn_done", 32'(done), 32'd1);
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err_in = 1'b0;
    core_req = 1'b0;
    tick();
    a_eacc = err_access;
    a_ebus = err_bus;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
    core_addr = 32'h0; core_wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err_in = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_flags", 32'({stall, err_access, err_bus, bus_we, bus_be}), 32'h0);

    // SW, grant in second REQ cycle, ack in first WAIT cycle
    do_txn(1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 1, 0, 32'h0, 1'b0);
    check("sw_addr", cap_addr, 32'h0000_0104);
    check("sw_be", 32'(cap_be), 32'hF);
    check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("sw_stall_cycles", 32'(stall_cyc), 32'd4);
    check("sw_no_err", 32'({d_eacc, d_ebus}), 32'd0);

    do_txn(1'b0, F3_B, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
    check("lb_rdata", d_rdata, 32'hFFFF_FF80);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_addr", cap_addr, 32'h0000_0200);
    do_txn(1'b0, F3_BU, 32'h0000_0203, 32'h0, 0, 1, 32'h80FF_1234, 1'b0);
    check("lbu_rdata", d_rdata, 32'h0000_0080);

    do_txn(1'b1, F3_H, 32'h0000_0102, 32'h0000_ABCD, 0, 0, 32'h0, 1'b0);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    do_txn(1'b0, F3_HU, 32'h0000_0102, 32'h0, 2, 0, 32'hABCD_0000, 1'b0);
    check("lhu_rdata", d_rdata, 32'h0000_ABCD);
    do_txn(1'b0, F3_H, 32'h0000_0100, 32'h0, 0, 0, 32'h1234_8001, 1'b0);
    check("lh_rdata", d_rdata, 32'hFFFF_8001);
    check("lh_be", 32'(cap_be), 32'h3);
    do_txn(1'b1, F3_B, 32'h0000_0101, 32'h0000_005A, 0, 0, 32'h0, 1'b0);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);

    // bus error on a load forces zero data
    do_txn(1'b0, F3_W, 32'h0000_0300, 32'h0, 0, 0, 32'h1234_5678, 1'b1);
    check("berr_flag", 32'(d_ebus), 32'd1);
    check("berr_rdata", d_rdata, 32'h0);
    check("berr_clear", 32'(a_ebus), 32'd0);

    // illegal accesses never reach the bus
    do_txn(1'b0, F3_W, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 1'b0);
    check("lw_mis_eacc", 32'(d_eacc), 32'd1);
    check("lw_mis_noreq", 32'(saw_req), 32'd0);
    check("lw_mis_stall", 32'(stall_cyc), 32'd1);
    check("lw_mis_clear", 32'(a_eacc), 32'd0);
    do_txn(1'b0, F3_H, 32'h0000_0203, 32'h0, 0, 0, 32'h0, 1'b0);
    check("lh_mis_eacc", 32'(d_eacc), 32'd1);
    check("lh_mis_noreq", 32'(saw_req), 32'd0);
    check("lh_mis_stall", 32'(stall_cyc), 32'd1);
    do_txn(1'b1, F3_BU, 32'h0000_0200, 32'h0, 0, 0, 32'h0, 1'b0);
    check("sbu_eacc", 32'(d_eacc), 32'd1);
    do_txn(1'b0, 3'b011, 32'h0000_0200, 32'h0, 0, 0, 32'h0, 1'b0);
    check("f3_011_eacc", 32'(d_eacc), 32'd1);

    // timeout: grant never comes
    do_txn(1'b0, F3_W, 32'h0000_0500, 32'h0, -1, 0, 32'h0, 1'b0);
    check("tmo_req_cycles", 32'(req_cyc), 32'd8);
    check("tmo_stall_cycles", 32'(stall_cyc), 32'd9);
    check("tmo_err_bus", 32'(d_ebus), 32'd1);
    check("tmo_bus_req", 32'(d_breq), 32'd0);
    check("tmo_rdata", d_rdata, 32'h0);
    bus_rvalid = 1'b1; bus_err_in = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 1'b0; bus_err_in = 1'b0;
    tick();
    check("late_rvalid_ebus", 32'(err_bus), 32'd0);
    check("late_rvalid_rdata", core_rdata, 32'h0);
    check("late_rvalid_req", 32'(bus_req), 32'd0);
    do_txn(1'b0, F3_BU, 32'h0000_0601, 32'h0, 0, 0, 32'h0000_C300, 1'b0);
    check("post_tmo_lbu", d_rdata, 32'h0000_00C3);

    // asynchronous reset while waiting for the response
    core_req = 1'b1; core_we = 1'b0; core_funct3 = F3_W; core_addr = 32'h0000_0400;
    tick();
    check("pre_rst_req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; core_req = 1'b0;
    #2;
    check("pre_rst_addr", bus_addr, 32'h0000_0400);
    rst_n = 1'b0;
    #1;
    check("arst_addr", bus_addr, 32'h0);
    check("arst_rdata", core_rdata, 32'h0);
    check("arst_flags", 32'({bus_req, bus_we, bus_be, err_access, err_bus, stall}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, F3_W, 32'h0000_0404, 32'h0, 0, -1, 32'hCAFE_F00D, 1'b0);
    check("post_rst_stall", 32'(stall_cyc), 32'd2);
    check("post_rst_rdata", d_rdata, 32'hCAFE_F00D);
    check("post_rst_addr", cap_addr, 32'h0000_0404);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
